// File: rtl/repeated_subtractor.sv
// Signed divider built from repeated subtraction of magnitudes: one subtraction per
// enabled clock, start/done handshake, saturating quotient and an exposed iteration count.
module repeated_subtractor #(
   parameter int WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder,
   output logic        [WIDTH-1:0] flag,
   output logic                    div_by_zero,
   output logic                    saturated
);

   localparam int MW = WIDTH + 1;

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] NEG1_W = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] QMAX_W = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [MW-1:0]    ZERO_M = {MW{1'b0}};
   localparam logic [MW-1:0]    ONE_M  = {{(MW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Magnitude is one bit wider than the operand so that |most-negative| is exact.
   function automatic logic [MW-1:0] abs_mag(input logic [WIDTH-1:0] v);
      logic [MW-1:0] ext;
      ext = {v[WIDTH-1], v};
      if (v[WIDTH-1]) begin
         return ~ext + ONE_M;
      end else begin
         return ext;
      end
   endfunction

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   state_t            state_q, state_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic [MW-1:0]     rem_mag_q, rem_mag_d;
   logic [MW-1:0]     div_mag_q, div_mag_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  quot_q, quot_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic [WIDTH-1:0]  flag_q, flag_d;
   logic              dbz_q, dbz_d;
   logic              sat_q, sat_d;

   logic              q_neg_s;
   logic              q_ovf_s;
   logic [WIDTH-1:0]  q_signed_s;
   logic [WIDTH-1:0]  r_signed_s;

   // Signed result candidates formed from the current magnitudes and count.
   always_comb begin
      q_neg_s    = sign_a_q ^ sign_b_q;
      q_ovf_s    = 1'b0;
      q_signed_s = count_q;
      r_signed_s = rem_mag_q[WIDTH-1:0];
      if (q_neg_s) begin
         q_signed_s = negate(count_q);
      end else begin
         q_ovf_s = (count_q > QMAX_W);
      end
      if (sign_a_q) begin
         r_signed_s = negate(rem_mag_q[WIDTH-1:0]);
      end else begin
         r_signed_s = rem_mag_q[WIDTH-1:0];
      end
   end

   // Next-state and next-output logic; everything holds while ena is low.
   always_comb begin
      state_d   = state_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      rem_mag_d = rem_mag_q;
      div_mag_d = div_mag_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = done_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      flag_d    = flag_q;
      dbz_d     = dbz_q;
      sat_d     = sat_q;
      if (ena) begin
         case (state_q)
            S_IDLE: begin
               done_d = 1'b0;
               if (start) begin
                  sign_a_d  = a[WIDTH-1];
                  sign_b_d  = b[WIDTH-1];
                  rem_mag_d = abs_mag(a);
                  div_mag_d = abs_mag(b);
                  count_d   = ZERO_W;
                  if (b == ZERO_W) begin
                     state_d = S_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     quot_d  = a[WIDTH-1] ? NEG1_W : QMAX_W;
                     rem_d   = a;
                     flag_d  = ZERO_W;
                     dbz_d   = 1'b1;
                     sat_d   = 1'b1;
                  end else begin
                     state_d = S_RUN;
                     busy_d  = 1'b1;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               if (rem_mag_q >= div_mag_q) begin
                  rem_mag_d = rem_mag_q - div_mag_q;
                  count_d   = count_q + ONE_W;
               end else begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  quot_d  = q_ovf_s ? QMAX_W : q_signed_s;
                  sat_d   = q_ovf_s;
                  rem_d   = r_signed_s;
                  flag_d  = count_q;
                  dbz_d   = 1'b0;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end
            default: begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               done_d    = 1'b0;
               rem_mag_d = ZERO_M;
               div_mag_d = ZERO_M;
               count_d   = ZERO_W;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         rem_mag_q <= ZERO_M;
         div_mag_q <= ZERO_M;
         count_q   <= ZERO_W;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         quot_q    <= ZERO_W;
         rem_q     <= ZERO_W;
         flag_q    <= ZERO_W;
         dbz_q     <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         rem_mag_q <= rem_mag_d;
         div_mag_q <= div_mag_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         flag_q    <= flag_d;
         dbz_q     <= dbz_d;
         sat_q     <= sat_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign flag        = flag_q;
   assign div_by_zero = dbz_q;
   assign saturated   = sat_q;

endmodule

// File: tb/tb_repeated_subtractor.sv
// Directed and randomized checks of repeated_subtractor against an arithmetic reference model.
module tb_repeated_subtractor;

   logic              clk;
   logic              rst_n;
   logic              ena;
   logic              start;
   logic signed [5:0] a;
   logic signed [5:0] b;
   logic              busy;
   logic              done;
   logic signed [5:0] quotient;
   logic signed [5:0] remainder;
   logic        [5:0] flag;
   logic              div_by_zero;
   logic              saturated;

   int checks   = 0;
   int failures = 0;

   repeated_subtractor #(.WIDTH(6)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .flag(flag), .div_by_zero(div_by_zero), .saturated(saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: truncating signed division with saturation, plus expected timing.
   function automatic void model(input int ai, input int bi,
                                 output int q, output int r, output int f,
                                 output int lat, output int bsy,
                                 output int dbz, output int sat);
      int ma, mb, k;
      if (bi == 0) begin
         q = (ai < 0) ? -1 : 31;
         r = ai; f = 0; lat = 1; bsy = 0; dbz = 1; sat = 1;
      end else begin
         ma = (ai < 0) ? -ai : ai;
         mb = (bi < 0) ? -bi : bi;
         k  = ma / mb;
         q  = ((ai < 0) != (bi < 0)) ? -k : k;
         sat = (q > 31) ? 1 : 0;
         if (q > 31) q = 31;
         r  = (ai < 0) ? -(ma % mb) : (ma % mb);
         f = k; lat = k + 2; bsy = k + 1; dbz = 0;
      end
   endfunction

   task automatic do_div(input int ai, input int bi, input string tag,
                         input int pause_at, input int pause_len,
                         input bit poke, input bit hold_done);
      int eq, er, ef, elat, ebsy, edbz, esat;
      int edges, busy_cnt;
      logic [5:0] av, bv;
      model(ai, bi, eq, er, ef, elat, ebsy, edbz, esat);
      elat = elat + pause_len;
      ebsy = ebsy + pause_len;
      av = ai[5:0];
      bv = bi[5:0];
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      start = 1'b0;
      a = 6'($urandom);
      b = 6'($urandom);
      busy_cnt = 0;
      while (done !== 1'b1 && edges < 200) begin
         if (busy === 1'b1) busy_cnt++;
         if (pause_len > 0 && edges == pause_at) begin
            ena = 1'b0;
            repeat (pause_len) begin
               @(posedge clk);
               edges++;
               @(negedge clk);
               if (busy === 1'b1) busy_cnt++;
            end
            ena = 1'b1;
         end
         if (poke && edges == 3) begin
            start = 1'b1; a = 6'sd1; b = 6'sd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, ".done"}, done, 1);
      chk({tag, ".latency"}, edges, elat);
      chk({tag, ".busy_cycles"}, busy_cnt, ebsy);
      chk({tag, ".quotient"}, $signed(quotient), eq);
      chk({tag, ".remainder"}, $signed(remainder), er);
      chk({tag, ".flag"}, flag, ef);
      chk({tag, ".div_by_zero"}, div_by_zero, edbz);
      chk({tag, ".saturated"}, saturated, esat);
      if (hold_done) begin
         ena = 1'b0;
         repeat (3) @(negedge clk);
         chk({tag, ".done_frozen"}, done, 1);
         ena = 1'b1;
      end
      @(negedge clk);
      chk({tag, ".done_pulse_end"}, done, 0);
      chk({tag, ".quotient_hold"}, $signed(quotient), eq);
   endtask

   initial begin
      int spurious;
      int ra, rb;
      rst_n = 1'b0; ena = 1'b1; start = 1'b1; a = 6'sd5; b = 6'sd1;
      #95;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.quotient", quotient, 0);
      chk("rst.remainder", remainder, 0);
      chk("rst.flag", flag, 0);
      chk("rst.div_by_zero", div_by_zero, 0);
      chk("rst.saturated", saturated, 0);
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      spurious = 0;
      repeat (6) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      chk("post_rst.idle", spurious, 0);

      do_div(30, 5, "d30_5", 0, 0, 1'b0, 1'b0);
      do_div(-17, 5, "dm17_5", 0, 0, 1'b0, 1'b0);
      do_div(7, -2, "d7_m2", 0, 0, 1'b0, 1'b0);
      do_div(-32, -1, "dm32_m1", 0, 0, 1'b0, 1'b0);
      do_div(-32, 1, "dm32_1", 0, 0, 1'b0, 1'b0);
      do_div(12, 0, "d12_0", 0, 0, 1'b0, 1'b1);
      do_div(-3, 0, "dm3_0", 0, 0, 1'b0, 1'b0);
      do_div(3, 7, "d3_7", 0, 0, 1'b0, 1'b0);
      do_div(30, 1, "ena_pause", 10, 5, 1'b0, 1'b0);
      do_div(30, 5, "start_poke", 0, 0, 1'b1, 1'b0);

      @(negedge clk);
      a = 6'sd30; b = 6'sd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", busy, 0);
      chk("abort.done", done, 0);
      chk("abort.quotient", quotient, 0);
      chk("abort.remainder", remainder, 0);
      chk("abort.flag", flag, 0);
      chk("abort.saturated", saturated, 0);
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      chk("abort.no_done", spurious, 0);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom_range(63, 0) - 32;
         rb = $urandom_range(63, 0) - 32;
         do_div(ra, rb, $sformatf("rnd%0d", i), 0, 0, 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
